// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (one-cycle read latency) into
// a valid/ready stream. A two-entry skid buffer plus an in-flight flag lets
// reads be issued speculatively so the stream sustains one beat per cycle,
// while never requesting more words than the buffer can hold. Beats are
// grouped into bursts of BURST_LEN with m_last_o marking the final beat.
// FIFO underflow discards the returning word and raises a sticky error.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_underflow_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  err_o
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic [1:0]            occ_q;
  logic                  in_flight_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  err_q;

  logic                  handshake;
  logic                  capture;
  logic [2:0]            committed;

  // Stream side: head of the buffer is presented whenever it holds a word.
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf_q[head_q];
  assign m_last_o  = m_valid_o && (beat_cnt_q == LAST_BEAT);
  assign err_o     = err_q;

  // Read request: only issue when the word is guaranteed a buffer slot,
  // counting words already held, the one in flight and the one leaving now.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    handshake    = 1'b0;
    capture      = 1'b0;
    committed    = 3'd0;
    fifo_rd_en_o = 1'b0;
    handshake    = m_valid_o && m_ready_i;
    capture      = in_flight_q && !fifo_underflow_i;
    committed    = 3'(occ_q) + 3'(in_flight_q) - 3'(handshake);
    fifo_rd_en_o = rst_n_i && en_i && !fifo_empty_i && (committed < 3'd2);
  end

  // Buffer storage and pointers: write at tail on capture, pop head on handshake.
  // NOTE: the buffer entries are reset too, so m_data_o reads zero in reset
  // rather than stale data; with two entries the cost is negligible.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (capture) begin
        buf_q[tail_q] <= fifo_rd_data_i;
        tail_q        <= ~tail_q;
      end
      if (handshake) head_q <= ~head_q;
      occ_q <= occ_q + 2'(capture) - 2'(handshake);
    end
  end

  // Outstanding-read flag: the FIFO returns data the cycle after a request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) in_flight_q <= 1'b0;
    else          in_flight_q <= fifo_rd_en_o;
  end

  // Burst beat counter: advances per transferred beat, wraps after the last.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_cnt_q <= '0;
    end else if (handshake) begin
      if (beat_cnt_q == LAST_BEAT) beat_cnt_q <= '0;
      else                         beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // Sticky error: set when an outstanding read comes back as an underflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                             err_q <= 1'b0;
    else if (in_flight_q && fifo_underflow_i) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader (DATA_WIDTH=8, BURST_LEN=4).
// A queue models the FIFO read side: a sampled read request pops a word that
// is presented one cycle later. Inputs change 1 time unit after the rising
// edge, outputs are sampled 1 unit later, well away from the next edge.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       en_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_rd_data_i;
  logic       fifo_underflow_i;
  logic       fifo_rd_en_o;
  logic       m_valid_o;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       m_ready_i;
  logic       err_o;

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n_i),
    .en_i             (en_i),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_rd_data_i   (fifo_rd_data_i),
    .fifo_underflow_i (fifo_underflow_i),
    .fifo_rd_en_o     (fifo_rd_en_o),
    .m_valid_o        (m_valid_o),
    .m_data_o         (m_data_o),
    .m_last_o         (m_last_o),
    .m_ready_i        (m_ready_i),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  int         rd_count = 0;
  int         first_rd = -1;
  bit         inj_uf   = 1'b0;
  logic [7:0] fifo_q [$];
  logic [7:0] beat_q [$];
  logic       last_q [$];
  int         cyc_q  [$];
  logic       s_rd, s_valid, s_last, s_err;
  logic [7:0] s_data;

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic clear_log();
    beat_q.delete();
    last_q.delete();
    cyc_q.delete();
    rd_count = 0;
    first_rd = -1;
  endtask

  // One clock cycle: sample outputs, log transfers, then model the FIFO.
  task automatic step();
    logic [7:0] w;
    #1;
    s_rd    = fifo_rd_en_o;
    s_valid = m_valid_o;
    s_data  = m_data_o;
    s_last  = m_last_o;
    s_err   = err_o;
    if (s_valid && m_ready_i) begin
      beat_q.push_back(s_data);
      last_q.push_back(s_last);
      cyc_q.push_back(cyc);
    end
    if (s_rd) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    fifo_underflow_i = 1'b0;
    if (s_rd) begin
      w = 8'h00;
      if (fifo_q.size() > 0) w = fifo_q.pop_front();
      else                   inj_uf = 1'b1;
      if (inj_uf) begin
        fifo_underflow_i = 1'b1;
        inj_uf           = 1'b0;
      end else begin
        fifo_rd_data_i = w;
      end
    end
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; en_i = 1'b1; m_ready_i = 1'b1;
    fifo_rd_data_i = 8'h00; fifo_underflow_i = 1'b0; fifo_empty_i = 1'b1;
    push(8'h99);
    #2;
    n_checks++;
    if (fifo_rd_en_o !== 1'b0) begin n_errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en_o); end
    n_checks++;
    if ({m_valid_o, m_last_o, err_o} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags: valid/last/err got %b want 000", {m_valid_o, m_last_o, err_o});
    end
    n_checks++;
    if (m_data_o !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", m_data_o); end
    @(posedge clk); #1;
    n_checks++;
    if (fifo_rd_en_o !== 1'b0 || m_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_hold: rd_en %b valid %b want 0 0", fifo_rd_en_o, m_valid_o);
    end
    fifo_q.delete(); fifo_empty_i = 1'b1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_streaming();
    clear_log();
    en_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (14) step();
    n_checks++;
    if (beat_q.size() != 8) begin n_errors++; $display("FAIL stream_count: got %0d beats want 8", beat_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (beat_q[i] !== 8'(i + 1)) begin n_errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, beat_q[i], 8'(i + 1)); end
        n_checks++;
        if (last_q[i] !== (i == 3 || i == 7)) begin n_errors++; $display("FAIL stream_last[%0d]: got %b want %b", i, last_q[i], (i == 3 || i == 7)); end
        n_checks++;
        if (cyc_q[i] !== cyc_q[0] + i) begin n_errors++; $display("FAIL stream_rate[%0d]: cycle %0d want %0d", i, cyc_q[i], cyc_q[0] + i); end
      end
      n_checks++;
      if (cyc_q[0] - first_rd !== 2) begin n_errors++; $display("FAIL stream_latency: got %0d want 2", cyc_q[0] - first_rd); end
    end
    n_checks++;
    if (rd_count !== 8 || s_rd !== 1'b0) begin n_errors++; $display("FAIL stream_reads: reads %0d rd_en %b want 8 0", rd_count, s_rd); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    clear_log();
    en_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    repeat (3) step();
    m_ready_i = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) held = s_data;
      else begin
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== held) begin
          n_errors++; $display("FAIL bp_stable[%0d]: valid %b data %h want 1 %h", i, s_valid, s_data, held);
        end
        n_checks++;
        if (s_rd !== 1'b0) begin n_errors++; $display("FAIL bp_rd_en[%0d]: got %b want 0", i, s_rd); end
      end
    end
    m_ready_i = 1'b1;
    repeat (15) step();
    n_checks++;
    if (beat_q.size() != 8) begin n_errors++; $display("FAIL bp_count: got %0d beats want 8", beat_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (beat_q[i] !== 8'h10 + 8'(i) || last_q[i] !== (i == 3 || i == 7)) begin
          n_errors++; $display("FAIL bp_beat[%0d]: data %h last %b want %h %b", i, beat_q[i], last_q[i], 8'h10 + 8'(i), (i == 3 || i == 7));
        end
      end
    end
  endtask

  task automatic test_empty();
    clear_log();
    en_i = 1'b1; m_ready_i = 1'b1;
    push(8'hA5);
    repeat (6) step();
    n_checks++;
    if (rd_count !== 1) begin n_errors++; $display("FAIL empty_reads: got %0d want 1", rd_count); end
    n_checks++;
    if (beat_q.size() != 1) begin n_errors++; $display("FAIL empty_count: got %0d beats want 1", beat_q.size()); end
    else begin
      n_checks++;
      if (beat_q[0] !== 8'hA5 || last_q[0] !== 1'b0) begin
        n_errors++; $display("FAIL empty_beat: data %h last %b want a5 0", beat_q[0], last_q[0]);
      end
    end
    n_checks++;
    if (s_rd !== 1'b0 || s_err !== 1'b0) begin n_errors++; $display("FAIL empty_idle: rd_en %b err %b want 0 0", s_rd, s_err); end
  endtask

  task automatic test_underflow();
    clear_log();
    en_i = 1'b1; m_ready_i = 1'b1;
    push(8'h33);
    inj_uf = 1'b1;
    repeat (6) step();
    n_checks++;
    if (beat_q.size() != 0) begin n_errors++; $display("FAIL uf_no_beat: got %0d beats want 0", beat_q.size()); end
    n_checks++;
    if (s_err !== 1'b1) begin n_errors++; $display("FAIL uf_err_set: got %b want 1", s_err); end
    push(8'h44);
    repeat (6) step();
    n_checks++;
    if (beat_q.size() != 1) begin n_errors++; $display("FAIL uf_resume_count: got %0d beats want 1", beat_q.size()); end
    else begin
      n_checks++;
      if (beat_q[0] !== 8'h44) begin n_errors++; $display("FAIL uf_resume_data: got %h want 44", beat_q[0]); end
    end
    n_checks++;
    if (s_err !== 1'b1) begin n_errors++; $display("FAIL uf_err_sticky: got %b want 1", s_err); end
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (err_o !== 1'b0) begin n_errors++; $display("FAIL uf_err_clear: got %b want 0", err_o); end
    fifo_q.delete(); fifo_empty_i = 1'b1;
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    int budget;
    clear_log();
    en_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    budget = 0;
    while (beat_q.size() < 2 && budget < 20) begin
      step();
      budget++;
    end
    n_checks++;
    if (beat_q.size() < 2) begin n_errors++; $display("FAIL rmb_timeout: got %0d beats want 2", beat_q.size()); end
    n_checks++;
    if (m_valid_o !== 1'b1) begin n_errors++; $display("FAIL rmb_pre_valid: got %b want 1", m_valid_o); end
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (m_valid_o !== 1'b0 || err_o !== 1'b0 || fifo_rd_en_o !== 1'b0) begin
      n_errors++; $display("FAIL rmb_async: valid %b err %b rd_en %b want 0 0 0", m_valid_o, err_o, fifo_rd_en_o);
    end
    fifo_q.delete(); fifo_empty_i = 1'b1;
    step();
    rst_n_i = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    repeat (10) step();
    n_checks++;
    if (beat_q.size() != 4) begin n_errors++; $display("FAIL rmb_count: got %0d beats want 4", beat_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (beat_q[i] !== 8'h60 + 8'(i) || last_q[i] !== (i == 3)) begin
          n_errors++; $display("FAIL rmb_beat[%0d]: data %h last %b want %h %b", i, beat_q[i], last_q[i], 8'h60 + 8'(i), (i == 3));
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    clear_log();
    en_i = 1'b1; m_ready_i = 1'b1;
    push(8'h70); push(8'h71); push(8'h72);
    step();
    en_i = 1'b0;
    repeat (5) step();
    n_checks++;
    if (rd_count !== 1 || s_rd !== 1'b0) begin n_errors++; $display("FAIL en_gate_reads: reads %0d rd_en %b want 1 0", rd_count, s_rd); end
    n_checks++;
    if (beat_q.size() != 1) begin n_errors++; $display("FAIL en_inflight_count: got %0d beats want 1", beat_q.size()); end
    else begin
      n_checks++;
      if (beat_q[0] !== 8'h70) begin n_errors++; $display("FAIL en_inflight_data: got %h want 70", beat_q[0]); end
    end
    en_i = 1'b1;
    repeat (8) step();
    n_checks++;
    if (rd_count !== 3 || beat_q.size() != 3) begin
      n_errors++; $display("FAIL en_resume: reads %0d beats %0d want 3 3", rd_count, beat_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (beat_q[i] !== 8'h70 + 8'(i) || last_q[i] !== 1'b0) begin
          n_errors++; $display("FAIL en_resume_beat[%0d]: data %h last %b want %h 0", i, beat_q[i], last_q[i], 8'h70 + 8'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty();
    test_underflow();
    test_reset_mid_burst();
    test_enable_gating();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
